// File: rtl/wav_dfi_lp_req_ctrl.sv
// DFI low-power request sequencer: drives lp_ctrl_req/lp_ctrl_wakeup from a host level
// request and watches lp_ctrl_ack so the DFI lp handshake rules always hold.
module wav_dfi_lp_req_ctrl #(
    parameter int TLP_RESP     = 8,
    parameter int ACK_DROP_MAX = 16,
    parameter int WAKEUP_W     = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                lp_en,
    input  logic [WAKEUP_W-1:0] lp_wakeup_in,
    input  logic                init_start,
    input  logic                lp_ctrl_ack,
    output logic                lp_ctrl_req,
    output logic [WAKEUP_W-1:0] lp_ctrl_wakeup,
    output logic                lp_active,
    output logic                lp_timeout,
    output logic                lp_done,
    output logic                proto_err,
    output logic [2:0]          state_o
);

    localparam int CNT_MAX = (TLP_RESP > ACK_DROP_MAX) ? TLP_RESP : ACK_DROP_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] TLP_LAST  = CNT_W'(TLP_RESP - 1);
    localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(ACK_DROP_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACKED = 3'd2,
        EXIT  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             timeout_n;
    logic             done_n;
    logic             err_n;
    logic             load_wakeup;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        timeout_n   = 1'b0;
        done_n      = 1'b0;
        err_n       = 1'b0;
        load_wakeup = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (lp_en && !init_start && !lp_ctrl_ack) begin
                    load_wakeup = 1'b1;
                    state_n     = REQ;
                end
            end
            REQ: begin
                // ack wins over both cancel and timeout when they coincide
                if (lp_ctrl_ack) begin
                    state_n = ACKED;
                end else if (!lp_en) begin
                    state_n = ABORT;
                end else if (cnt == TLP_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = ABORT;
                end else begin
                    cnt_n = sat_inc(cnt);
                end
            end
            ACKED: begin
                cnt_n = '0;
                if (!lp_en) begin
                    state_n = EXIT;
                end else if (!lp_ctrl_ack) begin
                    err_n   = 1'b1;
                    state_n = EXIT;
                end
            end
            EXIT: begin
                if (!lp_ctrl_ack) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = sat_inc(cnt);
                    err_n = (cnt == DROP_LAST);
                end
            end
            ABORT: begin
                cnt_n = '0;
                if (!lp_ctrl_ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // outputs are registered from the next state so req follows lp_en by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            lp_ctrl_req    <= 1'b0;
            lp_ctrl_wakeup <= '0;
            lp_active      <= 1'b0;
            lp_timeout     <= 1'b0;
            lp_done        <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            lp_ctrl_req <= (state_n == REQ) || (state_n == ACKED);
            lp_active   <= (state_n == ACKED);
            lp_timeout  <= timeout_n;
            lp_done     <= done_n;
            proto_err   <= err_n;
            if (load_wakeup) begin
                lp_ctrl_wakeup <= lp_wakeup_in;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_wav_dfi_lp_req_ctrl.sv
// Bench for wav_dfi_lp_req_ctrl: directed handshake scenarios plus a randomized PHY/host,
// all checked against a phase-level reference model of the lp handshake rules.
module tb_wav_dfi_lp_req_ctrl;

    localparam int TLP_RESP     = 8;
    localparam int ACK_DROP_MAX = 16;
    localparam int WAKEUP_W     = 6;

    localparam int PH_IDLE  = 0;
    localparam int PH_REQ   = 1;
    localparam int PH_ACKED = 2;
    localparam int PH_EXIT  = 3;
    localparam int PH_ABORT = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                lp_en = 1'b0;
    logic [WAKEUP_W-1:0] lp_wakeup_in = '0;
    logic                init_start = 1'b0;
    logic                lp_ctrl_ack = 1'b0;
    logic                lp_ctrl_req;
    logic [WAKEUP_W-1:0] lp_ctrl_wakeup;
    logic                lp_active;
    logic                lp_timeout;
    logic                lp_done;
    logic                proto_err;
    logic [2:0]          state_o;

    int total = 0;
    int bad   = 0;

    wav_dfi_lp_req_ctrl #(
        .TLP_RESP    (TLP_RESP),
        .ACK_DROP_MAX(ACK_DROP_MAX),
        .WAKEUP_W    (WAKEUP_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .lp_en         (lp_en),
        .lp_wakeup_in  (lp_wakeup_in),
        .init_start    (init_start),
        .lp_ctrl_ack   (lp_ctrl_ack),
        .lp_ctrl_req   (lp_ctrl_req),
        .lp_ctrl_wakeup(lp_ctrl_wakeup),
        .lp_active     (lp_active),
        .lp_timeout    (lp_timeout),
        .lp_done       (lp_done),
        .proto_err     (proto_err),
        .state_o       (state_o)
    );

    always #5 clock = ~clock;

    // Reference model: handshake phase, how long req has been up unanswered,
    // and how long ack has lingered after req was withdrawn.
    int                  m_phase   = PH_IDLE;
    int                  req_age   = 0;
    int                  stuck     = 0;
    logic [WAKEUP_W-1:0] m_wakeup  = '0;
    logic                m_timeout = 1'b0;
    logic                m_done    = 1'b0;
    logic                m_err     = 1'b0;

    task automatic model_step();
        m_timeout = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        if (reset) begin
            m_phase  = PH_IDLE;
            m_wakeup = '0;
        end else begin
            case (m_phase)
                PH_IDLE: if (lp_en && !init_start && !lp_ctrl_ack) begin
                    m_phase  = PH_REQ;
                    m_wakeup = lp_wakeup_in;
                    req_age  = 1;
                end
                PH_REQ: begin
                    if (lp_ctrl_ack) m_phase = PH_ACKED;
                    else if (!lp_en) m_phase = PH_ABORT;
                    else if (req_age == TLP_RESP) begin
                        m_timeout = 1'b1;
                        m_phase   = PH_ABORT;
                    end else req_age++;
                end
                PH_ACKED: begin
                    if (!lp_en) begin
                        m_phase = PH_EXIT;
                        stuck   = 0;
                    end else if (!lp_ctrl_ack) begin
                        m_err   = 1'b1;
                        m_phase = PH_EXIT;
                        stuck   = 0;
                    end
                end
                PH_EXIT: begin
                    if (!lp_ctrl_ack) begin
                        m_done  = 1'b1;
                        m_phase = PH_IDLE;
                    end else begin
                        stuck++;
                        if (stuck == ACK_DROP_MAX) m_err = 1'b1;
                    end
                end
                default: if (!lp_ctrl_ack) m_phase = PH_IDLE;
            endcase
        end
    endtask

    function automatic logic [13:0] model_vec();
        logic r;
        logic a;
        r = (m_phase == PH_REQ) || (m_phase == PH_ACKED);
        a = (m_phase == PH_ACKED);
        return {r, m_wakeup, a, m_timeout, m_done, m_err, 3'(m_phase)};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {lp_ctrl_req, lp_ctrl_wakeup, lp_active, lp_timeout, lp_done, proto_err, state_o};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic go_idle();
        lp_en       = 1'b0;
        lp_ctrl_ack = 1'b0;
        init_start  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (dut_vec() !== 14'h0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 14'h0);
        end
        reset = 1'b0;
    endtask

    // entry, ack 3 cycles after req, exit with ack dropping 2 cycles after lp_en falls
    task automatic test_enter_exit();
        logic [1:0] stim [8];
        logic [5:0] want [8];
        logic [5:0] got;
        stim = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        // {req, active, done, state}
        want = '{6'b100_001, 6'b100_001, 6'b100_001, 6'b110_010,
                 6'b000_011, 6'b000_011, 6'b001_000, 6'b000_000};
        lp_wakeup_in = 6'h05;
        for (int i = 0; i < 8; i++) begin
            lp_en       = stim[i][1];
            lp_ctrl_ack = stim[i][0];
            tick();
            got = {lp_ctrl_req, lp_active, lp_done, state_o};
            total++;
            if (got !== want[i]) begin
                bad++;
                $display("FAIL enter_exit[%0d]: got %b want %b", i, got, want[i]);
            end
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL enter_exit_model[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        total++;
        if (lp_ctrl_wakeup !== 6'h05) begin
            bad++;
            $display("FAIL enter_exit_wakeup: got %h want %h", lp_ctrl_wakeup, 6'h05);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        int  hi = 0;
        int  lows = 0;
        logic fell = 1'b0;
        logic tout = 1'b0;
        logic again = 1'b0;
        lp_wakeup_in = 6'h2A;
        lp_en        = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL timeout_model[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
            if (lp_ctrl_req) hi++;
            else if (hi > 0) begin
                fell = 1'b1;
                tout = lp_timeout;
                break;
            end
        end
        total++;
        if (!fell || hi != TLP_RESP || !tout) begin
            bad++;
            $display("FAIL timeout_len: got hi=%0d pulse=%0d want hi=%0d pulse=1", hi, tout, TLP_RESP);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (lp_ctrl_req) begin
                again = 1'b1;
                break;
            end
            lows++;
        end
        total++;
        if (!again || lows != 1 || lp_ctrl_wakeup !== 6'h2A) begin
            bad++;
            $display("FAIL timeout_rereq: got again=%0d lows=%0d wk=%h want 1 1 2a", again, lows, lp_ctrl_wakeup);
        end
        go_idle();
    endtask

    task automatic test_late_ack();
        logic seen = 1'b0;
        lp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lp_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL late_ack_timeout: got no pulse want pulse");
        end
        lp_en       = 1'b0;
        lp_ctrl_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (state_o !== 3'd4 || proto_err !== 1'b0 || lp_ctrl_req !== 1'b0) begin
                bad++;
                $display("FAIL late_ack_wait[%0d]: got st=%0d err=%0d req=%0d want 4 0 0", i, state_o, proto_err, lp_ctrl_req);
            end
        end
        lp_ctrl_ack = 1'b0;
        tick();
        total++;
        if (state_o !== 3'd0 || proto_err !== 1'b0 || dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL late_ack_idle: got %h want %h", dut_vec(), model_vec());
        end
        go_idle();
    endtask

    task automatic test_ack_drop();
        logic [1:0] stim [6];
        logic [6:0] want [6];
        logic [6:0] got;
        stim = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
        // {req, active, err, done, state}
        want = '{7'b1000_001, 7'b1100_010, 7'b1100_010, 7'b0010_011, 7'b0001_000, 7'b0000_000};
        for (int i = 0; i < 6; i++) begin
            lp_en       = stim[i][1];
            lp_ctrl_ack = stim[i][0];
            tick();
            got = {lp_ctrl_req, lp_active, proto_err, lp_done, state_o};
            total++;
            if (got !== want[i]) begin
                bad++;
                $display("FAIL ack_drop[%0d]: got %b want %b", i, got, want[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_exit_stuck();
        int errs = 0;
        int err_at = -1;
        lp_en = 1'b1;
        tick();
        lp_ctrl_ack = 1'b1;
        tick();
        lp_en = 1'b0;
        for (int i = 1; i <= ACK_DROP_MAX + 6; i++) begin
            tick();
            if (proto_err) begin
                errs++;
                err_at = i;
            end
        end
        total++;
        if (errs != 1 || err_at != ACK_DROP_MAX + 1) begin
            bad++;
            $display("FAIL exit_stuck: got errs=%0d at=%0d want 1 at %0d", errs, err_at, ACK_DROP_MAX + 1);
        end
        lp_ctrl_ack = 1'b0;
        tick();
        total++;
        if (lp_done !== 1'b1 || state_o !== 3'd0) begin
            bad++;
            $display("FAIL exit_stuck_done: got done=%0d st=%0d want 1 0", lp_done, state_o);
        end
        go_idle();
    endtask

    task automatic test_ack_priority();
        lp_en = 1'b1;
        repeat (TLP_RESP) tick();
        lp_ctrl_ack = 1'b1;
        tick();
        total++;
        if (lp_active !== 1'b1 || lp_timeout !== 1'b0 || lp_ctrl_req !== 1'b1) begin
            bad++;
            $display("FAIL ack_priority: got act=%0d tout=%0d req=%0d want 1 0 1", lp_active, lp_timeout, lp_ctrl_req);
        end
        go_idle();
    endtask

    task automatic test_init_block();
        init_start = 1'b1;
        lp_en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (lp_ctrl_req !== 1'b0) begin
                bad++;
                $display("FAIL init_block[%0d]: got req=%0d want 0", i, lp_ctrl_req);
            end
        end
        init_start = 1'b0;
        tick();
        total++;
        if (lp_ctrl_req !== 1'b1) begin
            bad++;
            $display("FAIL init_release: got req=%0d want 1", lp_ctrl_req);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        lp_wakeup_in = 6'h3C;
        lp_en        = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (dut_vec() !== 14'h0) begin
            bad++;
            $display("FAIL reset_in_req: got %h want %h", dut_vec(), 14'h0);
        end
        reset = 1'b0;
        tick();
        lp_ctrl_ack = 1'b1;
        tick();
        total++;
        if (lp_active !== 1'b1) begin
            bad++;
            $display("FAIL reset_reach_acked: got act=%0d want 1", lp_active);
        end
        reset = 1'b1;
        tick();
        total++;
        if (dut_vec() !== 14'h0) begin
            bad++;
            $display("FAIL reset_in_acked: got %h want %h", dut_vec(), 14'h0);
        end
        reset = 1'b0;
        go_idle();
    endtask

    task automatic test_random();
        int shown = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) lp_en = ~lp_en;
            init_start   = ($urandom_range(0, 7) == 0);
            lp_wakeup_in = WAKEUP_W'($urandom);
            reset        = ($urandom_range(0, 299) == 0);
            if (m_phase == PH_REQ || m_phase == PH_ACKED) begin
                if ($urandom_range(0, 2) == 0) lp_ctrl_ack = 1'b1;
            end else if ($urandom_range(0, 1) == 0) lp_ctrl_ack = 1'b0;
            if ($urandom_range(0, 24) == 0) lp_ctrl_ack = ~lp_ctrl_ack;
            if ($urandom_range(0, 199) == 0) lp_ctrl_ack = 1'b1;
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                if (shown < 10) $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
                shown++;
            end
            total++;
            if ((lp_timeout + lp_done + proto_err) > 2'd1) begin
                bad++;
                $display("FAIL random_excl[%0d]: got t=%0d d=%0d e=%0d want at most one", i, lp_timeout, lp_done, proto_err);
            end
        end
        reset = 1'b0;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_enter_exit();
        test_timeout();
        test_late_ack();
        test_ack_drop();
        test_exit_stuck();
        test_ack_priority();
        test_init_block();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
